// File: rtl/traffic_light_controller.sv
// traffic_light_controller: free-running green/orange/red sequencer with per-phase dwell counter
module traffic_light_controller #(
  parameter int g_time = 30,
  parameter int o_time = 5,
  parameter int r_time = 10
) (
  input  logic clk,
  input  logic rst,
  output logic green_light,
  output logic orange_light,
  output logic red_light
);
  localparam int max_t = (g_time > o_time) ? ((g_time > r_time) ? g_time : r_time)
                                           : ((o_time > r_time) ? o_time : r_time);
  localparam int cw = (max_t > 1) ? $clog2(max_t) : 1;
  typedef enum logic [1:0] {GREEN = 2'b00, ORANGE = 2'b01, RED = 2'b10, BAD = 2'b11} state_t;
  if (g_time < 1 || o_time < 1 || r_time < 1) begin : g_bad_cfg
    $error("traffic_light_controller: every phase time must be >= 1");
  end
  state_t state, state_nxt;
  logic [cw-1:0] cnt, cnt_nxt, lim;
  logic done;
  // state and dwell counter; reset drops straight back to the start of GREEN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GREEN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  // advance phase when the counter reaches the phase's last cycle; unused code falls to RED
  always_comb begin
    lim = (state == GREEN) ? cw'(g_time - 1) : (state == ORANGE) ? cw'(o_time - 1) : cw'(r_time - 1);
    done = (cnt == lim);
    state_nxt = (state == BAD)    ? RED :
                !done             ? state :
                (state == GREEN)  ? ORANGE :
                (state == ORANGE) ? RED : GREEN;
    cnt_nxt = (state == BAD || done) ? '0 : cnt + cw'(1);
  end
  assign green_light  = (state == GREEN);
  assign orange_light = (state == ORANGE);
  assign red_light    = (state == RED);
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of three parameterisations sharing clock and reset
module tb_traffic_light_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic g0, o0, r0, g1, o1, r1, g2, o2, r2;
  logic [2:0] lamps [3];
  int gt [3] = '{30, 1, 3};
  int ot [3] = '{5, 1, 2};
  int rt [3] = '{10, 1, 4};
  int vec = 0;
  int errs = 0;
  traffic_light_controller u_def (.clk(clk), .rst(rst), .green_light(g0), .orange_light(o0), .red_light(r0));
  traffic_light_controller #(.g_time(1), .o_time(1), .r_time(1)) u_min (.clk(clk), .rst(rst), .green_light(g1), .orange_light(o1), .red_light(r1));
  traffic_light_controller #(.g_time(3), .o_time(2), .r_time(4)) u_asym (.clk(clk), .rst(rst), .green_light(g2), .orange_light(o2), .red_light(r2));
  assign lamps[0] = {g0, o0, r0};
  assign lamps[1] = {g1, o1, r1};
  assign lamps[2] = {g2, o2, r2};

  function automatic logic [2:0] exp_lamps(int m, int g, int o, int r);
    int p;
    p = m % (g + o + r);
    return (p < g) ? 3'b100 : (p < g + o) ? 3'b010 : 3'b001;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (lamps[i] !== 3'b100) begin
          errs++;
          $display("FAIL reset dut%0d got %b want 100", i, lamps[i]);
        end
      end
    end
  endtask

  task automatic test_full_sequence();
    rst = 1'b1;
    for (int m = 0; m <= 140; m++) begin
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (lamps[i] !== exp_lamps(m, gt[i], ot[i], rt[i])) begin
          errs++;
          $display("FAIL sequence dut%0d edges=%0d got %b want %b", i, m, lamps[i], exp_lamps(m, gt[i], ot[i], rt[i]));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_one_hot();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vec++;
        if ($countones(lamps[i]) != 1) begin
          errs++;
          $display("FAIL one_hot dut%0d cycle=%0d got %b want exactly one lamp", i, c, lamps[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (32) @(negedge clk);
    vec++;
    if (lamps[0] !== 3'b010) begin
      errs++;
      $display("FAIL mid_reset_pre dut0 got %b want 010", lamps[0]);
    end
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (lamps[i] !== 3'b100) begin
        errs++;
        $display("FAIL mid_reset_async dut%0d got %b want 100", i, lamps[i]);
      end
    end
    #2 rst = 1'b1;
    for (int m = 1; m <= 31; m++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vec++;
        if (lamps[i] !== exp_lamps(m, gt[i], ot[i], rt[i])) begin
          errs++;
          $display("FAIL mid_reset_dwell dut%0d edges=%0d got %b want %b", i, m, lamps[i], exp_lamps(m, gt[i], ot[i], rt[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_one_hot();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
